// File: rtl/step_cmd_pkg.sv
// step_cmd_pkg: shared types and constants for the step command generator.
//   state_t       : command FSM states (IDLE, FIRE, HOLD)
//   CMD_*         : 2-bit step codes driven onto {w1,w0}
//   KEY_*         : bit positions of each key in the per-key vectors
package step_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP1  = 2'b01;
  localparam logic [1:0] CMD_UP2  = 2'b10;
  localparam logic [1:0] CMD_DOWN = 2'b11;

  localparam int NUM_KEYS = 3;
  localparam int KEY_UP1  = 0;
  localparam int KEY_UP2  = 1;
  localparam int KEY_DOWN = 2;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer plus counter debouncer for one raw
// active-low pushbutton.
//   Clock  in  system clock, rising edge
//   Reset  in  synchronous, active-high; everything returns to "released"
//   key_n  in  raw asynchronous button, active-low
//   level  out debounced level (1 = released, 0 = pressed), registered
//   press  out one-cycle pulse in the cycle the debounced level falls 1->0
// The release of a key is observed through 'level' itself, which stays valid
// however long the consumer ignores it.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        // Any agreeing sample restarts the count, so bounces never add up.
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        press_reg <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/step_command_gen.sv
// step_command_gen: turns three raw active-low pushbuttons into single-cycle
// step codes for the mod-10 step counter, with auto-repeat on long holds.
//   Clock      in  system clock, rising edge
//   Reset      in  synchronous, active-high
//   KeyUp1_n   in  raw button, active-low, issues +1 (01)
//   KeyUp2_n   in  raw button, active-low, issues +2 (10)
//   KeyDown_n  in  raw button, active-low, issues -1 (11)
//   w1, w0     out step code {w1,w0}, registered; 00 between commands
//   Active     out high while a key is latched (FIRE or HOLD), registered
// REPEAT_DELAY and REPEAT_RATE must both be at least 2.
module step_command_gen
  import step_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyUp1_n,
  input  logic KeyUp2_n,
  input  logic KeyDown_n,
  output logic w1,
  output logic w0,
  output logic Active
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] key_raw_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  assign key_raw_n[KEY_UP1]  = KeyUp1_n;
  assign key_raw_n[KEY_UP2]  = KeyUp2_n;
  assign key_raw_n[KEY_DOWN] = KeyDown_n;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (key_raw_n[gi]),
        .level (key_level[gi]),
        .press (key_press[gi])
      );
    end
  endgenerate

  // Priority encoder for presses landing on the same cycle: Down > Up2 > Up1.
  logic                press_any;
  logic [1:0]          press_code;
  logic [NUM_KEYS-1:0] press_mask;

  always_comb begin
    press_any  = 1'b1;
    press_code = CMD_HOLD;
    press_mask = '0;
    if (key_press[KEY_DOWN]) begin
      press_code           = CMD_DOWN;
      press_mask[KEY_DOWN] = 1'b1;
    end else if (key_press[KEY_UP2]) begin
      press_code          = CMD_UP2;
      press_mask[KEY_UP2] = 1'b1;
    end else if (key_press[KEY_UP1]) begin
      press_code          = CMD_UP1;
      press_mask[KEY_UP1] = 1'b1;
    end else begin
      press_any = 1'b0;
    end
  end

  state_t              state_reg;
  logic [1:0]          code_reg;
  logic [NUM_KEYS-1:0] key_mask_reg;
  logic                first_reg;
  logic [RW-1:0]       rpt_reg;
  logic [1:0]          cmd_reg;
  logic                active_reg;

  logic          latched_released;
  logic [RW-1:0] rpt_dec;

  // Only the latched key's debounced level matters once a key is latched.
  assign latched_released = |(key_level & key_mask_reg);
  // Expiry is judged on the decremented value so repeats land exactly
  // REPEAT_DELAY / REPEAT_RATE cycles after the previous command.
  assign rpt_dec = rpt_reg - 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      code_reg     <= CMD_HOLD;
      key_mask_reg <= '0;
      first_reg    <= 1'b0;
      rpt_reg      <= '0;
      cmd_reg      <= CMD_HOLD;
      active_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press_any) begin
            state_reg    <= FIRE;
            code_reg     <= press_code;
            key_mask_reg <= press_mask;
            first_reg    <= 1'b1;
            cmd_reg      <= press_code;
            active_reg   <= 1'b1;
          end else begin
            cmd_reg    <= CMD_HOLD;
            active_reg <= 1'b0;
          end
        end
        FIRE: begin
          state_reg  <= HOLD;
          rpt_reg    <= first_reg ? RPT_FIRST : RPT_NEXT;
          first_reg  <= 1'b0;
          cmd_reg    <= CMD_HOLD;
          active_reg <= 1'b1;
        end
        HOLD: begin
          rpt_reg <= rpt_dec;
          if (latched_released) begin
            // Release wins over a simultaneous repeat expiry.
            state_reg  <= IDLE;
            cmd_reg    <= CMD_HOLD;
            active_reg <= 1'b0;
          end else if (rpt_dec == '0) begin
            state_reg  <= FIRE;
            cmd_reg    <= code_reg;
            active_reg <= 1'b1;
          end else begin
            cmd_reg    <= CMD_HOLD;
            active_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          cmd_reg    <= CMD_HOLD;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign w1     = cmd_reg[1];
  assign w0     = cmd_reg[0];
  assign Active = active_reg;

endmodule

// File: tb/tb_step_command_gen.sv
// tb_step_command_gen: self-checking bench for step_command_gen with small
// debounce / repeat parameters. Expected pulses (cycle, code) are queued when
// a key is driven and compared when the DUT shows a non-00 code.
module tb_step_command_gen;
  import step_cmd_pkg::*;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic Clock     = 1'b0;
  logic Reset     = 1'b1;
  logic KeyUp1_n  = 1'b1;
  logic KeyUp2_n  = 1'b1;
  logic KeyDown_n = 1'b1;
  logic w1, w0, Active;

  step_command_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .KeyUp1_n (KeyUp1_n),
    .KeyUp2_n (KeyUp2_n),
    .KeyDown_n(KeyDown_n),
    .w1       (w1),
    .w0       (w0),
    .Active   (Active)
  );

  always #5 Clock = ~Clock;

  // cyc equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   z     = 0;
  logic [1:0] prev_out = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [1:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic set_key(input int key, input logic v);
    case (key)
      KEY_UP1: KeyUp1_n  = v;
      KEY_UP2: KeyUp2_n  = v;
      default: KeyDown_n = v;
    endcase
  endtask

  // Hold one key low for h sampled edges, queueing the initial command and
  // every auto-repeat that falls strictly before the debounced release.
  task automatic press_key(input int key, input int h, input logic [1:0] code);
    int k, t;
    @(negedge Clock);
    k = cyc + 1;
    t = k + 2 + D;
    set_key(key, 1'b0);
    if (h >= D) begin
      expect_pulse(t, code);
      for (int x = RD; x < h; x += RR) expect_pulse(t + x, code);
    end
    repeat (h) @(negedge Clock);
    set_key(key, 1'b1);
  endtask

  task automatic settle(input string tag);
    repeat (D + 12) @(negedge Clock);
    #1;
    check({tag, "_active_idle"}, Active, 0);
    check({tag, "_queue_empty"}, sb.size(), 0);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge Clock) begin
    logic [1:0] out;
    exp_t e;
    out = {w1, w0};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_pulse: got 00 at cycle %0d, required %b", e.cyc, e.code);
    end
    if (out !== CMD_HOLD) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, required 00", out, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.code !== out) begin
          fails++;
          $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", out, cyc, e.code, e.cyc);
        end
      end
      check("active_on_pulse", Active, 1);
      check("no_back_to_back", prev_out, 0);
      case (out)
        CMD_UP1:  z = (z + 1) % 10;
        CMD_UP2:  z = (z + 2) % 10;
        CMD_DOWN: z = (z + 9) % 10;
        default:  ;
      endcase
    end
    prev_out = out;
  end

  typedef struct {
    int         key;
    int         hold;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int k;
    vecs[0] = '{KEY_UP1,  6,  CMD_UP1};   // single press
    vecs[1] = '{KEY_UP1,  3,  CMD_UP1};   // glitch shorter than debounce
    vecs[2] = '{KEY_UP1,  4,  CMD_UP1};   // shortest accepted press
    vecs[3] = '{KEY_UP2,  6,  CMD_UP2};
    vecs[4] = '{KEY_DOWN, 6,  CMD_DOWN};
    vecs[5] = '{KEY_DOWN, 8,  CMD_DOWN};  // release meets repeat expiry
    vecs[6] = '{KEY_DOWN, 9,  CMD_DOWN};  // first repeat just makes it
    vecs[7] = '{KEY_DOWN, 30, CMD_DOWN};  // long hold with repeats
    vecs[8] = '{KEY_UP2,  13, CMD_UP2};

    // Reset state.
    repeat (3) begin
      @(negedge Clock);
      check("reset_out", {w1, w0}, 0);
      check("reset_active", Active, 0);
    end
    Reset = 1'b0;
    repeat (20) @(negedge Clock);
    #1;
    check("idle_out", {w1, w0}, 0);
    check("idle_active", Active, 0);

    // Table of single-key holds.
    for (int i = 0; i < 9; i++) begin
      press_key(vecs[i].key, vecs[i].hold, vecs[i].code);
      settle($sformatf("vec%0d", i));
    end

    // Bounce pattern 0,1,0,1: never debounces.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      KeyUp1_n = i[0];
    end
    settle("bounce");

    // Up2 and Down together: Down wins; held Up2 must not fire later.
    @(negedge Clock);
    k = cyc + 1;
    KeyUp2_n  = 1'b0;
    KeyDown_n = 1'b0;
    expect_pulse(k + 2 + D, CMD_DOWN);
    repeat (6) @(negedge Clock);
    KeyDown_n = 1'b1;
    repeat (20) @(negedge Clock);
    #1;
    check("simul_active_idle", Active, 0);
    check("simul_queue_empty", sb.size(), 0);
    KeyUp2_n = 1'b1;
    repeat (D + 8) @(negedge Clock);
    press_key(KEY_UP2, 6, CMD_UP2);
    settle("repress_up2");

    // Reset in the middle of a hold.
    @(negedge Clock);
    k = cyc + 1;
    KeyUp1_n = 1'b0;
    expect_pulse(k + 2 + D, CMD_UP1);
    repeat (2 + D + 3) @(negedge Clock);
    #1;
    check("hold_active", Active, 1);
    Reset = 1'b1;
    @(negedge Clock);
    #1;
    check("midreset_out", {w1, w0}, 0);
    check("midreset_active", Active, 0);
    Reset = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 2 + D, CMD_UP1);
    repeat (7) @(negedge Clock);
    KeyUp1_n = 1'b1;
    settle("after_reset");

    // Chain into a mod-10 counter: 12 x (+1) lands on 2.
    z = 0;
    for (int i = 0; i < 12; i++) begin
      press_key(KEY_UP1, 5, CMD_UP1);
      settle("chain");
    end
    check("chain_z", z, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d, required end", cyc);
    $fatal(1, "timeout");
  end

endmodule
